// File: rtl/pcieifc_fifo_pkg.sv
// pcieifc_fifo_pkg
// Shared sizing helpers for the pcieifc FIFO controller slice.
//   clog2        - pointer width helper (bits needed to index a given depth)
//   count_width  - occupancy counter width for a given memory address width
// No ports; imported by the interface, the pointer sub-module and the top.
package pcieifc_fifo_pkg;

   // Ceiling log2, usable in constant expressions for parameter math.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

   // Occupancy spans 0..DEPTH+1, which always fits in ADDRSIZE+1 bits for ADDRSIZE >= 1.
   function automatic int count_width(input int addrsize);
      return addrsize + 1;
   endfunction

   localparam int DEFAULT_ADDRSIZE = 4;
   localparam int DEFAULT_CNT_W    = count_width(DEFAULT_ADDRSIZE);

endpackage

// File: rtl/pcieifc_sync_fifo_ctrl_if.sv
// pcieifc_sync_fifo_ctrl_if
// Producer/consumer side of the FWFT FIFO controller.
//   master : the PCIe-side producer and the downstream consumer (drive requests)
//   slave  : the FIFO controller (drives data, status flags and occupancy)
// Signals: flush, wr_en, wr_data, dout_ready (requests); full, almost_full,
// overflow, dout, dout_valid, empty, almost_empty, count (status/data).
interface pcieifc_sync_fifo_ctrl_if
   import pcieifc_fifo_pkg::*;
#(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
);

   logic                             flush;
   logic                             wr_en;
   logic [DATASIZE-1:0]              wr_data;
   logic                             full;
   logic                             almost_full;
   logic                             overflow;
   logic [DATASIZE-1:0]              dout;
   logic                             dout_valid;
   logic                             dout_ready;
   logic                             empty;
   logic                             almost_empty;
   logic [count_width(ADDRSIZE)-1:0] count;

   modport master (
      output flush, wr_en, wr_data, dout_ready,
      input  full, almost_full, overflow, dout, dout_valid, empty, almost_empty, count
   );

   modport slave (
      input  flush, wr_en, wr_data, dout_ready,
      output full, almost_full, overflow, dout, dout_valid, empty, almost_empty, count
   );

endinterface

// File: rtl/pcieifc_fifo_ptr.sv
// pcieifc_fifo_ptr
// One FIFO pointer with a wrap bit in the MSB. Used once for the write
// pointer and once for the read pointer.
//   clk  - clock
//   rst  - synchronous active-high reset (pointer to 0)
//   clr  - synchronous flush (pointer to 0)
//   inc  - advance the pointer by one
//   ptr  - current pointer value, PTR_W bits
module pcieifc_fifo_ptr
   import pcieifc_fifo_pkg::*;
#(
   parameter int PTR_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // Natural binary roll-over gives the seamless lower-bit wrap and MSB toggle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/pcieifc_sync_fifo_ctrl.sv
// pcieifc_sync_fifo_ctrl
// First-word-fall-through controller around an external pcieifc FIFO memory
// (registered write port, combinational read mux). Owns the pointers, the
// status flags and a one-entry registered output stage, so total capacity is
// DEPTH in memory plus one held at dout.
//   clk, rst        - single clock, synchronous active-high reset
//   bus (slave)     - producer/consumer handshake, flags and occupancy
//   mem_wdata/waddr/wclken/wfull - memory write port
//   mem_raddr/mem_rdata          - memory read mux (rdata combinational in raddr)
// The memory's wrst_n is tied to ~rst at the level above this block.
module pcieifc_sync_fifo_ctrl
   import pcieifc_fifo_pkg::*;
#(
   parameter int DATASIZE      = 8,
   parameter int ADDRSIZE      = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   pcieifc_sync_fifo_ctrl_if.slave  bus,
   output logic [DATASIZE-1:0]      mem_wdata,
   output logic [ADDRSIZE-1:0]      mem_waddr,
   output logic [ADDRSIZE-1:0]      mem_raddr,
   output logic                     mem_wclken,
   output logic                     mem_wfull,
   input  logic [DATASIZE-1:0]      mem_rdata
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam int PTR_W = clog2(DEPTH) + 1;
   localparam int CNT_W = count_width(ADDRSIZE);

   localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AFULL_P  = PTR_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

   logic [PTR_W-1:0]    wptr;
   logic [PTR_W-1:0]    rptr;
   logic [PTR_W-1:0]    mem_count;
   logic                mem_empty;
   logic                full;
   logic                wr_accept;
   logic                load;
   logic [DATASIZE-1:0] dout_q;
   logic                dout_valid_q;
   logic                overflow_q;

   // Modulo subtraction of wrap-bit pointers yields 0..DEPTH directly.
   assign mem_count = wptr - rptr;
   assign mem_empty = (wptr == rptr);
   assign full      = (mem_count == DEPTH_P);

   // full is judged on the pre-edge state, so a pop in the same cycle does
   // not open a slot for a write that arrives while full.
   assign wr_accept = bus.wr_en & ~full & ~bus.flush;

   // Refill the output stage whenever it is empty or being consumed.
   assign load = ~mem_empty & (~dout_valid_q | bus.dout_ready) & ~bus.flush;

   assign mem_wclken = wr_accept;
   assign mem_waddr  = wptr[ADDRSIZE-1:0];
   assign mem_wdata  = bus.wr_data;
   assign mem_wfull  = full;
   assign mem_raddr  = rptr[ADDRSIZE-1:0];

   pcieifc_fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
      .clk (clk),
      .rst (rst),
      .clr (bus.flush),
      .inc (wr_accept),
      .ptr (wptr)
   );

   pcieifc_fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
      .clk (clk),
      .rst (rst),
      .clr (bus.flush),
      .inc (load),
      .ptr (rptr)
   );

   // Output stage and sticky overflow. Flush discards the held word as well
   // as anything in memory; memory contents themselves are left stale.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         if (load) begin
            dout_q       <= mem_rdata;
            dout_valid_q <= 1'b1;
         end else if (bus.dout_ready && dout_valid_q) begin
            dout_valid_q <= 1'b0;
         end
         if (bus.wr_en && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign bus.full         = full;
   assign bus.almost_full  = (mem_count >= AFULL_P);
   assign bus.overflow     = overflow_q;
   assign bus.dout         = dout_q;
   assign bus.dout_valid   = dout_valid_q;
   assign bus.empty        = ~dout_valid_q;
   assign bus.count        = CNT_W'(mem_count) + CNT_W'(dout_valid_q);
   assign bus.almost_empty = (bus.count <= AEMPTY_C);

endmodule

// File: doc/pcieifc_sync_fifo_ctrl.md
Name: pcieifc_sync_fifo_ctrl

Overview:
Single-clock controller that sequences one pcieifc FIFO memory instance (write port plus combinational read mux) as a first-word-fall-through (FWFT) FIFO. It owns the read and write pointers, full/empty/threshold flags and a one-entry registered output stage. It sits between a PCIe interface producer and a ready/valid consumer. The memory instance is external to this block and is wired to its mem_* ports.

Parameters:
DATASIZE, 8, data word width; must match the memory instance.
ADDRSIZE, 4, memory address bits; memory depth is DEPTH = 2^ADDRSIZE (power of two only).
AFULL_THRESH, 12, mem_count >= this value asserts almost_full; legal range 1..DEPTH.
AEMPTY_THRESH, 2, count <= this value asserts almost_empty; legal range 0..DEPTH.

Ports:
clk  in  1  single clock; also drives the memory wclk.
rst  in  1  synchronous, active-high reset. The top level ties the memory wrst_n to ~rst.
flush  in  1  synchronous clear of all FIFO contents.
wr_en  in  1  write request.
wr_data  in  DATASIZE  write data.
full  out  1  memory full; writes are refused while high.
almost_full  out  1  mem_count >= AFULL_THRESH.
overflow  out  1  sticky; set by wr_en while full.
dout  out  DATASIZE  head-of-FIFO data.
dout_valid  out  1  dout holds a valid entry.
dout_ready  in  1  consumer accepts dout this cycle.
empty  out  1  equal to ~dout_valid.
almost_empty  out  1  count <= AEMPTY_THRESH.
count  out  ADDRSIZE+1  total occupancy = mem_count + dout_valid; range 0..DEPTH+1.
mem_wdata  out  DATASIZE  to memory wdata.
mem_waddr  out  ADDRSIZE  to memory waddr.
mem_raddr  out  ADDRSIZE  to memory raddr.
mem_wclken  out  1  to memory wclken.
mem_wfull  out  1  to memory wfull.
mem_rdata  in  DATASIZE  from memory rdata; combinational in raddr.

Behaviour:
- Pointers
  - wptr and rptr are ADDRSIZE+1 bits, with a wrap bit in the MSB.
  - mem_count = wptr - rptr, computed modulo 2^(ADDRSIZE+1).
  - mem_empty = (wptr == rptr).
  - full = (mem_count == DEPTH), equivalently MSBs differ and lower bits are equal.
- Write path
  - wr_accept = wr_en & ~full & ~flush.
  - mem_wclken = wr_accept. mem_waddr = wptr[ADDRSIZE-1:0]. mem_wdata = wr_data. mem_wfull = full.
  - On wr_accept, wptr increments at the clock edge.
  - A write while full is dropped: wptr is unchanged and overflow is set.
  - full is evaluated before any same-cycle pop. A write arriving while full and while the output stage pops is still refused.
- Output stage (FWFT)
  - load = ~mem_empty & (~dout_valid | dout_ready) & ~flush.
  - mem_raddr = rptr[ADDRSIZE-1:0].
  - On load: dout <= mem_rdata, dout_valid <= 1, rptr increments.
  - On dout_ready & dout_valid & ~load: dout_valid <= 0.
  - dout_ready while ~dout_valid is ignored.
  - dout holds its value while dout_valid & ~dout_ready.
- Latency
  - A write accepted at edge N is in memory after edge N. It loads into dout at edge N+1.
  - dout_valid is therefore first visible 2 cycles after wr_en is sampled into an empty FIFO.
  - There is no write-to-output bypass.
- Sustained throughput: one write and one read per cycle with no bubbles.
- Capacity: DEPTH entries in memory plus 1 in dout, i.e. count reaches DEPTH+1 at most.
- Flags
  - full, almost_full, almost_empty and count are combinational from the registered state.
  - empty = ~dout_valid.
- Reset (rst = 1) and flush = 1
  - Both take effect at the next edge: wptr = rptr = 0, dout_valid = 0, dout = 0, overflow = 0.
  - Resulting outputs: full = 0, almost_full = 0, empty = 1, almost_empty = 1, count = 0.
  - rst has priority over flush. flush has priority over wr_en and dout_ready.
  - Memory contents are not cleared by flush; they are stale and unreachable.
- Reset or flush mid-stream: any in-flight write in that cycle is discarded.
- Wrap-around: pointer lower bits wrap from DEPTH-1 to 0 seamlessly; the MSB toggles on each wrap.

Decomposition:
- Shared package pcieifc_fifo_pkg holds:
  - the pointer-width function clog2;
  - the count-width localparam expression.
- Sub-module pcieifc_fifo_ptr: one pointer register with increment, flush and reset. It is instantiated twice, once for wptr and once for rptr.
- Output stage and flag logic are written inline in this block.

Test Plan:
- Reset and basic latency: assert rst for 2 cycles, then single wr_en with data 0xA5 and dout_ready = 0 → dout_valid = 1 and dout = 0xA5 exactly 2 cycles later; count = 1; empty = 0.
- Fill to capacity: dout_ready = 0, write 0x00..0x10 (17 words) at DEPTH = 16 → full = 1 after the 17th accepted write; count = 17; almost_full asserted from mem_count = 12; 18th write sets overflow and is dropped.
- Drain order: from the full state, hold dout_ready = 1 → dout = 0x00..0x10 in order, one per cycle; dout_valid = 0 and count = 0 after 17 cycles.
- Streaming with wrap: wr_en and dout_ready both high for 40 cycles with an incrementing pattern → no bubbles after the initial 2-cycle latency; data in order through two pointer wraps; full never asserts.
- Full with simultaneous pop: state full, wr_en = 1 and dout_ready = 1 in the same cycle → write refused, overflow = 1, one word popped; next cycle full = 0 and a write is accepted.
- Flush mid-stream: 5 entries stored, then flush = 1 together with wr_en = 1 → next cycle count = 0, dout_valid = 0, overflow = 0; the following write 0x3C appears at dout 2 cycles later.
